// File: rtl/sequenciador_ativos_pkg.sv
// Shared types and helpers for the active-node sequencer.
package sequenciador_ativos_pkg;

    typedef enum logic [2:0] {
        IDLE, SEMEAR, ESPERAR, SELECIONAR, DESATIVAR, PEDIR, RECEBER, FIM
    } estado_t;

    // Width needed to count 0..n inclusive.
    function automatic int largura_contador(input int n);
        return $clog2(n + 1);
    endfunction

    // Base bit of slot i in a flat bus of w-bit fields.
    function automatic int fatia(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/sequenciador_ativos_seletor.sv
// seletor_aprovado: combinational lowest-index priority encoder over the approval flags.
module seletor_aprovado #(
    parameter int NUM_NA = 8,
    parameter int IDX_W  = (NUM_NA > 1) ? $clog2(NUM_NA) : 1
) (
    input  logic [NUM_NA-1:0] i_aprovado,
    output logic [IDX_W-1:0]  o_indice,
    output logic              o_valido
);

    always_comb begin
        o_indice = '0;
        o_valido = 1'b0;
        // Scan downwards so the lowest set bit is the last one to win.
        for (int i = NUM_NA - 1; i >= 0; i--) begin
            if (i_aprovado[i]) begin
                o_indice = IDX_W'(i);
                o_valido = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sequenciador_ativos.sv
// Best-first search controller driving the active-node evaluator and neighbour memory.
// Optional expansion counter output enabled by SEQUENCIADOR_ATIVOS_CONTADOR_EN.
module sequenciador_ativos
    import sequenciador_ativos_pkg::*;
#(
    parameter int NUM_NA          = 8,
    parameter int ADR_WIDTH       = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int ESPERA_MAX      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_in,
    input  logic [ADR_WIDTH-1:0]           origem_in,
    input  logic [ADR_WIDTH-1:0]           destino_in,
    input  logic [NUM_NA-1:0]              aa_aprovado_in,
    input  logic [ADR_WIDTH*NUM_NA-1:0]    aa_endereco_in,
    input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
    output logic                           viz_req_out,
    output logic [ADR_WIDTH-1:0]           viz_no_out,
    input  logic                           viz_valid_in,
    input  logic [ADR_WIDTH-1:0]           viz_endereco_in,
    input  logic [CUSTO_WIDTH-1:0]         viz_custo_in,
    input  logic                           viz_ultimo_in,
    output logic                           desativar_out,
    output logic                           atualizar_out,
    output logic [ADR_WIDTH-1:0]           endereco_out,
    output logic [ADR_WIDTH-1:0]           anterior_out,
    output logic [CUSTO_WIDTH-1:0]         menor_vizinho_out,
    output logic [DISTANCIA_WIDTH-1:0]     distancia_out,
    output logic                           busy_out,
    output logic                           done_out,
    output logic                           encontrado_out
`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
    ,
    output logic [ADR_WIDTH-1:0]           expansoes_out
`endif
);

    localparam int IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
    localparam int CW    = largura_contador(ESPERA_MAX);
    localparam int DW    = DISTANCIA_WIDTH;

    estado_t                r_estado;
    logic [ADR_WIDTH-1:0]   r_origem, r_destino, r_sel_end;
    logic [DW-1:0]          r_sel_dist;
    logic [CW-1:0]          r_espera;

    logic [IDX_W-1:0]       w_indice;
    logic                   w_valido;
    logic [ADR_WIDTH-1:0]   w_end_sel;
    logic [DW-1:0]          w_dist_sel;
    logic [DW:0]            w_soma;
    logic [CW-1:0]          w_espera_prox;

    seletor_aprovado #(.NUM_NA(NUM_NA), .IDX_W(IDX_W)) u_seletor (
        .i_aprovado (aa_aprovado_in),
        .o_indice   (w_indice),
        .o_valido   (w_valido)
    );

    assign w_end_sel     = aa_endereco_in[fatia(int'(w_indice), ADR_WIDTH) +: ADR_WIDTH];
    assign w_dist_sel    = aa_distancia_in[fatia(int'(w_indice), DW) +: DW];
    // One extra bit so a carry out marks the beat as unreachable.
    assign w_soma        = {1'b0, r_sel_dist} + (DW+1)'(viz_custo_in);
    assign w_espera_prox = r_espera + CW'(1);

`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
    logic [ADR_WIDTH-1:0] r_expansoes;
    assign expansoes_out = r_expansoes;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado          <= IDLE;
            r_origem          <= '0;
            r_destino         <= '0;
            r_sel_end         <= '0;
            r_sel_dist        <= '0;
            r_espera          <= '0;
            viz_req_out       <= 1'b0;
            viz_no_out        <= '0;
            desativar_out     <= 1'b0;
            atualizar_out     <= 1'b0;
            endereco_out      <= '0;
            anterior_out      <= '0;
            menor_vizinho_out <= '0;
            distancia_out     <= '0;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            encontrado_out    <= 1'b0;
`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
            r_expansoes       <= '0;
`endif
        end else begin
            desativar_out <= 1'b0;
            atualizar_out <= 1'b0;
            viz_req_out   <= 1'b0;
            done_out      <= 1'b0;
            case (r_estado)
                IDLE: if (start_in) begin
                    r_origem       <= origem_in;
                    r_destino      <= destino_in;
                    encontrado_out <= 1'b0;
                    busy_out       <= 1'b1;
`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
                    r_expansoes    <= '0;
`endif
                    r_estado       <= SEMEAR;
                end
                SEMEAR: begin
                    atualizar_out     <= 1'b1;
                    endereco_out      <= r_origem;
                    anterior_out      <= r_origem;
                    menor_vizinho_out <= '0;
                    distancia_out     <= '0;
                    r_espera          <= '0;
                    r_estado          <= ESPERAR;
                end
                ESPERAR: begin
                    if (|aa_aprovado_in) begin
                        r_estado <= SELECIONAR;
                    end else if (w_espera_prox == CW'(ESPERA_MAX)) begin
                        done_out       <= 1'b1;
                        busy_out       <= 1'b0;
                        encontrado_out <= 1'b0;
                        r_estado       <= FIM;
                    end else begin
                        r_espera <= w_espera_prox;
                    end
                end
                SELECIONAR: begin
                    // Approval may have vanished since ESPERAR; simply wait again.
                    if (!w_valido) begin
                        r_espera <= '0;
                        r_estado <= ESPERAR;
                    end else begin
                        r_sel_end  <= w_end_sel;
                        r_sel_dist <= w_dist_sel;
                        if (w_end_sel == r_destino) begin
                            done_out       <= 1'b1;
                            busy_out       <= 1'b0;
                            encontrado_out <= 1'b1;
                            r_estado       <= FIM;
                        end else begin
`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
                            if (r_expansoes != '1) r_expansoes <= r_expansoes + 1'b1;
`endif
                            r_estado <= DESATIVAR;
                        end
                    end
                end
                DESATIVAR: begin
                    desativar_out <= 1'b1;
                    endereco_out  <= r_sel_end;
                    r_estado      <= PEDIR;
                end
                PEDIR: begin
                    viz_req_out <= 1'b1;
                    viz_no_out  <= r_sel_end;
                    r_estado    <= RECEBER;
                end
                RECEBER: if (viz_valid_in) begin
                    if (!w_soma[DW]) begin
                        atualizar_out     <= 1'b1;
                        endereco_out      <= viz_endereco_in;
                        anterior_out      <= r_sel_end;
                        menor_vizinho_out <= viz_custo_in;
                        distancia_out     <= w_soma[DW-1:0];
                    end
                    if (viz_ultimo_in) begin
                        r_espera <= '0;
                        r_estado <= ESPERAR;
                    end
                end
                FIM:     r_estado <= IDLE;
                default: r_estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_ativos.sv
// Directed bench for sequenciador_ativos: seeding, expansion, priority, overflow, timeout, reset.
module tb_sequenciador_ativos;

    localparam int NUM_NA = 8, ADR = 5, DW = 5, CW = 4, EMAX = 4;

    logic              clk = 1'b0, rst = 1'b1, start_in = 1'b0;
    logic [ADR-1:0]    origem_in = '0, destino_in = '0;
    logic [NUM_NA-1:0] aa_aprovado_in = '0;
    logic [ADR*NUM_NA-1:0] aa_endereco_in = '0;
    logic [DW*NUM_NA-1:0]  aa_distancia_in = '0;
    logic              viz_valid_in = 1'b0, viz_ultimo_in = 1'b0;
    logic [ADR-1:0]    viz_endereco_in = '0;
    logic [CW-1:0]     viz_custo_in = '0;
    logic              viz_req_out, desativar_out, atualizar_out;
    logic              busy_out, done_out, encontrado_out;
    logic [ADR-1:0]    viz_no_out, endereco_out, anterior_out;
    logic [CW-1:0]     menor_vizinho_out;
    logic [DW-1:0]     distancia_out;
`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
    logic [ADR-1:0]    expansoes_out;
`endif

    int n_tests = 0, n_fail = 0;

    sequenciador_ativos #(
        .NUM_NA(NUM_NA), .ADR_WIDTH(ADR), .DISTANCIA_WIDTH(DW),
        .CUSTO_WIDTH(CW), .ESPERA_MAX(EMAX)
    ) dut (
        .clk(clk), .rst(rst), .start_in(start_in),
        .origem_in(origem_in), .destino_in(destino_in),
        .aa_aprovado_in(aa_aprovado_in), .aa_endereco_in(aa_endereco_in),
        .aa_distancia_in(aa_distancia_in),
        .viz_req_out(viz_req_out), .viz_no_out(viz_no_out),
        .viz_valid_in(viz_valid_in), .viz_endereco_in(viz_endereco_in),
        .viz_custo_in(viz_custo_in), .viz_ultimo_in(viz_ultimo_in),
        .desativar_out(desativar_out), .atualizar_out(atualizar_out),
        .endereco_out(endereco_out), .anterior_out(anterior_out),
        .menor_vizinho_out(menor_vizinho_out), .distancia_out(distancia_out),
        .busy_out(busy_out), .done_out(done_out), .encontrado_out(encontrado_out)
`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
        , .expansoes_out(expansoes_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input int i, input logic [ADR-1:0] a, input logic [DW-1:0] d);
        aa_endereco_in[i*ADR +: ADR] = a;
        aa_distancia_in[i*DW +: DW]  = d;
    endtask

    task automatic beat(input logic [ADR-1:0] a, input logic [CW-1:0] c, input logic u);
        viz_valid_in = 1'b1; viz_endereco_in = a; viz_custo_in = c; viz_ultimo_in = u;
    endtask

    task automatic go(input logic [ADR-1:0] o, input logic [ADR-1:0] d);
        start_in = 1'b1; origem_in = o; destino_in = d;
        tick();
        start_in = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_enc", encontrado_out, 0);
        chk("rst_atu", atualizar_out, 0);

        // Seeding: origin == destination
        go(3, 3);
        chk("s_busy", busy_out, 1);
        chk("s_atu_early", atualizar_out, 0);
        tick();
        chk("s_atu", atualizar_out, 1);
        chk("s_end", endereco_out, 3);
        chk("s_ant", anterior_out, 3);
        chk("s_dist", distancia_out, 0);
        chk("s_menor", menor_vizinho_out, 0);
        aa_aprovado_in = 8'b0000_0001; slot(0, 3, 0);
        tick();
        chk("s_atu_off", atualizar_out, 0);
        tick();
        chk("s_done", done_out, 1);
        chk("s_enc", encontrado_out, 1);
        chk("s_busy_lo", busy_out, 0);
        chk("s_desat", desativar_out, 0);
        start_in = 1'b1;  // during FIM: must be ignored
        tick();
        start_in = 1'b0;
        aa_aprovado_in = '0;
        chk("s_done_lo", done_out, 0);
        chk("s_start_ign", busy_out, 0);
        chk("s_enc_hold", encontrado_out, 1);
        tick();
        chk("s_still_idle", busy_out, 0);

        // Expansion with priority: slots 2 and 5 approved, slot 2 wins
        go(1, 20);
        chk("e_enc_clr", encontrado_out, 0);
        tick();
        chk("e_seed", atualizar_out, 1);
        aa_aprovado_in = 8'b0010_0100; slot(2, 5, 7); slot(5, 6, 1);
        tick(); tick();
        chk("e_no_desat_yet", desativar_out, 0);
        tick();
        chk("e_desat", desativar_out, 1);
        chk("e_desat_end", endereco_out, 5);
        chk("e_desat_atu", atualizar_out, 0);
        aa_aprovado_in = '0;
        tick();
        chk("e_req", viz_req_out, 1);
        chk("e_req_no", viz_no_out, 5);
        chk("e_desat_lo", desativar_out, 0);
        beat(9, 2, 0);
        tick();
        chk("e_u1", atualizar_out, 1);
        chk("e_u1_end", endereco_out, 9);
        chk("e_u1_ant", anterior_out, 5);
        chk("e_u1_dist", distancia_out, 9);
        chk("e_u1_menor", menor_vizinho_out, 2);
        beat(11, 4, 1);
        tick();
        chk("e_u2", atualizar_out, 1);
        chk("e_u2_end", endereco_out, 11);
        chk("e_u2_dist", distancia_out, 11);
        viz_valid_in = 1'b0; viz_ultimo_in = 1'b0;

        // Overflow: selected distance 30 + 3 does not fit in 5 bits
        aa_aprovado_in = 8'b0000_0001; slot(0, 12, 30);
        tick(); tick(); tick();
        chk("o_desat_end", endereco_out, 12);
        aa_aprovado_in = '0;
        tick();
        chk("o_req_no", viz_no_out, 12);
        beat(13, 3, 0);
        tick();
        chk("o_drop", atualizar_out, 0);
        beat(14, 1, 1);
        tick();
        chk("o_next", atualizar_out, 1);
        chk("o_next_end", endereco_out, 14);
        chk("o_next_ant", anterior_out, 12);
        chk("o_next_dist", distancia_out, 31);
        viz_valid_in = 1'b0; viz_ultimo_in = 1'b0;

        // Failure: ESPERAR entered at the last edge, no approvals
        tick(); tick(); tick();
        chk("f_wait", done_out, 0);
        chk("f_busy", busy_out, 1);
        tick();
        chk("f_done", done_out, 1);
        chk("f_enc", encontrado_out, 0);
        chk("f_busy_lo", busy_out, 0);
`ifdef SEQUENCIADOR_ATIVOS_CONTADOR_EN
        chk("f_expansoes", expansoes_out, 2);
`endif
        tick();

        // Reset during RECEBER
        go(2, 25);
        tick();
        aa_aprovado_in = 8'b0000_0001; slot(0, 4, 0);
        tick(); tick(); tick();
        aa_aprovado_in = '0;
        tick();
        chk("r_req", viz_req_out, 1);
        beat(8, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0; viz_valid_in = 1'b0;
        chk("r_atu", atualizar_out, 0);
        chk("r_busy", busy_out, 0);
        chk("r_req_lo", viz_req_out, 0);
        chk("r_end", endereco_out, 0);
        tick();
        chk("r_idle_atu", atualizar_out, 0);

        // Normal search after reset
        go(7, 7);
        tick();
        chk("a_seed_end", endereco_out, 7);
        aa_aprovado_in = 8'b0000_0001; slot(0, 7, 0);
        tick(); tick();
        chk("a_done", done_out, 1);
        chk("a_enc", encontrado_out, 1);
        aa_aprovado_in = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
